// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline stage status in, front-end load/flush/bubble controls out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             ID_Branch;
  logic             ID_JumpReg;
  logic             ID_PCSel;
  logic             ID_MulDiv;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [4:0]       EX_WriteReg;
  logic             MEM_RegWrite;
  logic             MEM_MemRead;
  logic [4:0]       MEM_WriteReg;
  logic             PC_Ld;
  logic             IF_ID_Ld;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic             MulBusy;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_JumpReg, ID_PCSel, ID_MulDiv,
           EX_RegWrite, EX_MemRead, EX_WriteReg, MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
    input  PC_Ld, IF_ID_Ld, IF_ID_Flush, ID_EX_Bubble, MulBusy, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_JumpReg, ID_PCSel, ID_MulDiv,
           EX_RegWrite, EX_MemRead, EX_WriteReg, MEM_RegWrite, MEM_MemRead, MEM_WriteReg,
    output PC_Ld, IF_ID_Ld, IF_ID_Flush, ID_EX_Bubble, MulBusy, StallCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-operand hazard detection, wrong-path flush and HI/LO multi-cycle stall sequencer.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input logic                   Clk,
  input logic                   Rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int MC_W = $clog2(MUL_LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;
  logic            ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit, br_uses_rt;
  logic            lu, bh, mul_stall, mul_busy, stall;

  // Register $0 is never a real dependency, so every match requires a nonzero destination.
  always_comb begin
    ex_rs_hit  = (hz.EX_WriteReg != 5'd0) && (hz.EX_WriteReg == hz.ID_Rs);
    ex_rt_hit  = (hz.EX_WriteReg != 5'd0) && (hz.EX_WriteReg == hz.ID_Rt);
    mem_rs_hit = (hz.MEM_WriteReg != 5'd0) && (hz.MEM_WriteReg == hz.ID_Rs);
    mem_rt_hit = (hz.MEM_WriteReg != 5'd0) && (hz.MEM_WriteReg == hz.ID_Rt);
    br_uses_rt = hz.ID_Branch && hz.ID_UsesRt;
    lu = hz.EX_MemRead && hz.EX_RegWrite && (ex_rs_hit || (hz.ID_UsesRt && ex_rt_hit));
    bh = (hz.ID_Branch || hz.ID_JumpReg) &&
         ((hz.EX_RegWrite && (ex_rs_hit || (br_uses_rt && ex_rt_hit))) ||
          (hz.MEM_MemRead && hz.MEM_RegWrite && (mem_rs_hit || (br_uses_rt && mem_rt_hit))));
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    mul_stall = 1'b0;
    mul_busy  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hz.ID_MulDiv && !lu && !bh) begin
          mul_stall = 1'b1;
          mul_busy  = 1'b1;
          state_d   = BUSY;
          mul_cnt_d = MC_W'(MUL_LATENCY - 2);
        end
      end
      BUSY: begin
        mul_stall = 1'b1;
        mul_busy  = 1'b1;
        if (mul_cnt_q == '0) state_d = DONE;
        else                 mul_cnt_d = mul_cnt_q - MC_W'(1);
      end
      // DONE lets the held instruction advance without re-triggering on it.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q   <= IDLE;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign stall           = Rst && (lu || bh || mul_stall);
  assign hz.PC_Ld        = !stall;
  assign hz.IF_ID_Ld     = !stall;
  assign hz.ID_EX_Bubble = stall;
  assign hz.IF_ID_Flush  = Rst && hz.ID_PCSel && !stall;
  assign hz.MulBusy      = Rst && mul_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) stall_count_q <= '0;
    else      stall_count_q <= stall_count_d;
  end

  assign hz.StallCount = stall_count_q;
`else
  assign hz.StallCount = {CNT_W{1'b0}};
`endif

endmodule
